// File: rtl/system_bus_pkg.sv
// system_bus_pkg: shared bus encodings, default widths and the bus master state type.
package system_bus_pkg;
  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  typedef enum logic [2:0] {IDLE, REQ, ISSUE, WAIT, RESP} bus_master_state_t;
endpackage

// File: rtl/bus_timeout_ctr.sv
// bus_timeout_ctr: counts WAIT cycles; expired flags the last allowed cycle.
module bus_timeout_ctr #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);
  localparam int CW = $clog2(TIMEOUT_CYC);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (i_clear) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + CW'(1);
  end
  assign o_expired = r_cnt == CW'(TIMEOUT_CYC - 1);
endmodule

// File: rtl/bus_master.sv
// bus_master: turns one host command into a single bus transaction and returns the slave's
// response, or an error response when the slave stays silent past the timeout.
module bus_master #(
  parameter int ADDR_W      = system_bus_pkg::ADDR_W,
  parameter int DATA_W      = system_bus_pkg::DATA_W,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_mode,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              m_req,
  input  logic              m_grant,
  output logic              mode,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              m_valid,
  input  logic [DATA_W-1:0] rdata,
  input  logic              sl_valid,
  input  logic              sl_ready
);
  import system_bus_pkg::*;
  bus_master_state_t r_state, w_next;
  logic w_expired, w_done;
  assign cmd_ready = (r_state == IDLE) && rst_n;
  assign busy      = r_state != IDLE;
  assign w_done    = (r_state == WAIT) && (sl_valid || w_expired);
  bus_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (r_state == ISSUE),
    .i_en     ((r_state == WAIT) && !sl_valid && !w_expired),
    .o_expired(w_expired)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = cmd_valid ? REQ : IDLE;
      REQ:     w_next = (m_grant && sl_ready) ? ISSUE : REQ;
      ISSUE:   w_next = WAIT;
      WAIT:    w_next = w_done ? RESP : WAIT;
      RESP:    w_next = rsp_ready ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  // Bus fields change only on command accept so they stay stable through REQ and idle time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_req     <= 1'b0;
      m_valid   <= 1'b0;
      mode      <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      m_valid <= (r_state == REQ) && m_grant && sl_ready;
      if (r_state == IDLE && cmd_valid) begin
        mode  <= cmd_mode;
        addr  <= cmd_addr;
        wdata <= cmd_wdata;
        m_req <= 1'b1;
      end
      if (w_done) begin
        rsp_rdata <= sl_valid ? rdata : '0;
        rsp_err   <= !sl_valid;
        rsp_valid <= 1'b1;
        m_req     <= 1'b0;
      end
      if (r_state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bus_master.sv
// tb_bus_master: randomized scoreboard bench pairing bus_master with a simple memory slave.
module tb_bus_master;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_mode = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic rsp_valid, rsp_ready = 1'b1, rsp_err, busy, m_req, m_grant = 1'b1, mode, m_valid;
  logic [7:0] rsp_rdata, wdata, rdata;
  logic [15:0] addr;
  logic sl_valid, sl_ready = 1'b1, sl_silent = 1'b0;
  int cyc = 0, tests = 0, fails = 0;

  bus_master #(.ADDR_W(16), .DATA_W(8), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy), .m_req(m_req), .m_grant(m_grant),
    .mode(mode), .addr(addr), .wdata(wdata), .m_valid(m_valid), .rdata(rdata),
    .sl_valid(sl_valid), .sl_ready(sl_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory slave: answers three cycles after seeing m_valid; writes echo wdata.
  bit [7:0] slave_mem [65536];
  logic s_pend, s_mode;
  logic [1:0] s_cnt;
  logic [15:0] s_addr;
  logic [7:0] s_wd;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_pend <= 1'b0; sl_valid <= 1'b0; rdata <= '0; s_cnt <= '0;
    end else begin
      sl_valid <= 1'b0;
      if (m_valid && !sl_silent) begin
        s_pend <= 1'b1; s_cnt <= 2'd2; s_mode <= mode; s_addr <= addr; s_wd <= wdata;
      end else if (s_pend) begin
        if (s_cnt == 0) begin
          s_pend <= 1'b0; sl_valid <= 1'b1;
          if (s_mode) begin slave_mem[s_addr] <= s_wd; rdata <= s_wd; end
          else rdata <= slave_mem[s_addr];
        end else s_cnt <= s_cnt - 2'd1;
      end
    end
  end

  typedef struct {logic [7:0] data; logic err; int lat; int acc;} exp_t;
  exp_t q[$];
  logic [7:0] ref_mem [logic [15:0]];
  logic cur_mode = 1'b0;
  logic [15:0] cur_addr = '0;
  logic [7:0] cur_wdata = '0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic issue(input logic m, input logic [15:0] a, input logic [7:0] d, input int g,
                       input logic s);
    exp_t e;
    bit ok = 0;
    sl_silent = s;
    m_grant = (g == 0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_mode = m; cmd_addr = a; cmd_wdata = d;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      chk("cmd_accept", cmd_ready, 1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.acc = cyc;
    cmd_valid = 1'b0;
    cur_mode = m; cur_addr = a; cur_wdata = d;
    if (s) begin
      e.data = 8'h00; e.err = 1'b1; e.lat = 18 + g;
    end else begin
      e.err = 1'b0; e.lat = 6 + g;
      if (m) begin e.data = d; ref_mem[a] = d; end
      else e.data = ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    end
    q.push_back(e);
    if (g > 0) begin
      for (int i = 0; i < g; i++) begin
        @(negedge clk);
        chk("req_mreq", m_req, 1);
        chk("req_no_mvalid", m_valid, 0);
        chk("req_addr", addr, a);
      end
      @(negedge clk);
      m_grant = 1'b1;
      @(negedge clk);
      chk("mvalid_after_grant", m_valid, 1);
    end
  endtask

  task automatic finish_rsp();
    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
    chk("rsp_done", q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit prev_v = 0, prev_mv = 0;
    int rise = 0;
    exp_t e;
    repeat (3) @(negedge clk);
    chk("rst_mreq", m_req, 0);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_rspvalid", rsp_valid, 0);
    chk("rst_rsperr", rsp_err, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_bus", {mode, addr, wdata}, 0);
    chk("rst_cmdready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    fork
      forever begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
          prev_v = 0; prev_mv = 0;
        end else begin
          chk("bus_fields", {mode, addr, wdata}, {cur_mode, cur_addr, cur_wdata});
          if (m_valid) chk("mvalid_pulse", prev_mv, 0);
          if (rsp_valid) chk("rsp_mreq_low", m_req, 0);
          if (rsp_valid && !prev_v) rise = cyc;
          if (rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
              tests++; fails++;
              $display("FAIL rsp_unexpected: got response %0h with nothing expected", rsp_rdata);
            end else begin
              e = q.pop_front();
              chk("rsp_rdata", rsp_rdata, e.data);
              chk("rsp_err", rsp_err, e.err);
              chk("rsp_latency", rise - e.acc, e.lat);
            end
          end
          prev_v = rsp_valid; prev_mv = m_valid;
        end
      end
      begin
        issue(1'b1, 16'h0012, 8'hA5, 0, 1'b0); finish_rsp();
        issue(1'b0, 16'h0012, 8'h00, 0, 1'b0); finish_rsp();
        issue(1'b1, 16'h0034, 8'h5C, 10, 1'b0); finish_rsp();
        issue(1'b0, 16'h0040, 8'h00, 0, 1'b1); finish_rsp();
        rsp_ready = 1'b0;
        issue(1'b0, 16'h0034, 8'h00, 0, 1'b0);
        for (int i = 0; i < 30 && !rsp_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          cmd_valid = 1'b1; cmd_addr = 16'h0077; cmd_wdata = 8'hEE; cmd_mode = 1'b1;
          chk("hold_rspvalid", rsp_valid, 1);
          chk("hold_rdata", rsp_rdata, 8'h5C);
          chk("hold_cmdready", cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        finish_rsp();
        chk("hold_not_taken", busy, 0);
        issue(1'b1, 16'h0050, 8'h33, 0, 1'b1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mreq", m_req, 0);
        chk("mid_rst_mvalid", m_valid, 0);
        chk("mid_rst_rspvalid", rsp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        q.delete();
        cur_mode = 1'b0; cur_addr = '0; cur_wdata = '0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(1'b1, 16'h0060, 8'hC3, 0, 1'b0); finish_rsp();
        issue(1'b0, 16'h0060, 8'h00, 0, 1'b0); finish_rsp();
        for (int n = 0; n < 40; n++) begin
          issue(1'($urandom_range(0, 1)), 16'($urandom_range(0, 7)) << 4, 8'($urandom),
                int'($urandom_range(0, 3)), $urandom_range(0, 9) == 0);
          finish_rsp();
        end
      end
    join_any
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
